// File: rtl/zbus_port_dec_pkg.sv
// Shared constants for the Z80 AY port decoder: port address patterns,
// config-write prefix and FSM state encoding.
package zbus_port_dec_pkg;

  // {A15, A14, A1} patterns of the two AY ports
  localparam logic [2:0] PORT_REG   = 3'b110;  // #FFFD
  localparam logic [2:0] PORT_DAT   = 3'b100;  // #BFFD
  localparam logic [3:0] CFG_PREFIX = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic port_hit(input logic [2:0] addr, input logic [2:0] port);
    return (addr == port);
  endfunction

endpackage

// File: rtl/zbus_sync.sv
// Multi-flop synchroniser for one asynchronous Z80 strobe; resets to the
// inactive (high) level so no strobe is seen while reset is applied.
module zbus_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // shift the async input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/zbus_port_dec.sv
// Z80 I/O front end: synchronises the bus strobes, decodes #FFFD/#BFFD and
// generates config write strobes, timed AY write pulses and the read enable.
module zbus_port_dec
  import zbus_port_dec_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WR_PULSE    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       z_a15,
  input  logic       z_a14,
  input  logic       z_a1,
  input  logic       z_iorq_n,
  input  logic       z_m1_n,
  input  logic       z_wr_n,
  input  logic       z_rd_n,
  input  logic [7:0] z_d,
  output logic       cfg_wrstb,
  output logic [7:0] cfg_d,
  output logic       dev_wr_n,
  output logic       dev_a0,
  output logic [7:0] dev_wdata,
  output logic       dev_rd_n,
  output logic       busy
);

  localparam logic [3:0] PULSE_LOAD = 4'(WR_PULSE - 1);

  logic iorq_s, wr_s, rd_s, m1_s;
  logic wr_act_s, rd_act_s, sel_reg_s, sel_dat_s;

  zbus_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (.clk(clk), .rst_n(rst_n), .d_i(z_iorq_n), .q_o(iorq_s));
  zbus_sync #(.STAGES(SYNC_STAGES)) u_sync_wr   (.clk(clk), .rst_n(rst_n), .d_i(z_wr_n),   .q_o(wr_s));
  zbus_sync #(.STAGES(SYNC_STAGES)) u_sync_rd   (.clk(clk), .rst_n(rst_n), .d_i(z_rd_n),   .q_o(rd_s));
  zbus_sync #(.STAGES(SYNC_STAGES)) u_sync_m1   (.clk(clk), .rst_n(rst_n), .d_i(z_m1_n),   .q_o(m1_s));

  // M1 low together with IORQ is an interrupt acknowledge, never a port access
  assign wr_act_s  = ~iorq_s & ~wr_s & m1_s;
  assign rd_act_s  = ~iorq_s & ~rd_s & m1_s;
  assign sel_reg_s = port_hit({z_a15, z_a14, z_a1}, PORT_REG);
  assign sel_dat_s = port_hit({z_a15, z_a14, z_a1}, PORT_DAT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cfg_wrstb_q, cfg_wrstb_d;
  logic [7:0] cfg_data_q, cfg_data_d;
  logic       dev_wr_n_q, dev_wr_n_d;
  logic       dev_a0_q, dev_a0_d;
  logic [7:0] dev_wdata_q, dev_wdata_d;
  logic       dev_rd_n_q, dev_rd_n_d;
  logic       busy_q, busy_d;

  // next-state and registered-output logic of the write FSM and read path
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_wrstb_d = 1'b0;
    cfg_data_d  = cfg_data_q;
    dev_wr_n_d  = dev_wr_n_q;
    dev_a0_d    = dev_a0_q;
    dev_wdata_d = dev_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_act_s && sel_reg_s && (z_d[7:4] == CFG_PREFIX)) begin
          cfg_data_d  = z_d;
          cfg_wrstb_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (wr_act_s && (sel_reg_s || sel_dat_s)) begin
          dev_a0_d    = sel_dat_s;
          dev_wdata_d = z_d;
          dev_wr_n_d  = 1'b0;
          cnt_d       = PULSE_LOAD;
          state_d     = ST_PULSE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        // pulse length is fixed by the counter, not by how long /WR stays low
        if (cnt_q == 4'd0) begin
          dev_wr_n_d = 1'b1;
          state_d    = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (!wr_act_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        dev_wr_n_d = 1'b1;
        cnt_d      = 4'd0;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    // a concurrent write always wins over a read
    dev_rd_n_d = ~(rd_act_s & sel_reg_s) | wr_act_s | busy_d;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cfg_wrstb_q <= 1'b0;
      cfg_data_q  <= 8'hFF;
      dev_wr_n_q  <= 1'b1;
      dev_a0_q    <= 1'b0;
      dev_wdata_q <= 8'hFF;
      dev_rd_n_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_wrstb_q <= cfg_wrstb_d;
      cfg_data_q  <= cfg_data_d;
      dev_wr_n_q  <= dev_wr_n_d;
      dev_a0_q    <= dev_a0_d;
      dev_wdata_q <= dev_wdata_d;
      dev_rd_n_q  <= dev_rd_n_d;
      busy_q      <= busy_d;
    end
  end

  assign cfg_wrstb = cfg_wrstb_q;
  assign cfg_d     = cfg_data_q;
  assign dev_wr_n  = dev_wr_n_q;
  assign dev_a0    = dev_a0_q;
  assign dev_wdata = dev_wdata_q;
  assign dev_rd_n  = dev_rd_n_q;
  assign busy      = busy_q;

endmodule
